muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative RV32M multiply/divide unit that sits beside the ALU in the execute stage of the pipelined core. It accepts one operation per start pulse and computes it over multiple cycles, holding `busy` so the hazard unit can stall fetch/decode and freeze execute. It returns a one-cycle `done` pulse with the result and destination register, and is killed by `flush` on branch redirect.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (≥8, even)
- `REG_ADDR_W`, 5, destination register address width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  issue request; sampled only when state is IDLE
- `op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `src_a`  in  XLEN  rs1 operand (forwarded value)
- `src_b`  in  XLEN  rs2 operand (forwarded value)
- `rd_in`  in  REG_ADDR_W  destination register of issued op
- `flush`  in  1  abort in-flight op, no `done`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle result-valid pulse
- `result`  out  XLEN  result; valid only while `done`
- `rd_out`  out  REG_ADDR_W  destination register; valid while `done`

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE + `start` (and no `flush`): latch `op` and `rd_in`. Latch magnitudes of operands (signed per op: MULH/DIV/REM both signed, MULHSU only `src_a` signed). Record the result sign. Load iteration counter = XLEN and go to CALC.
- Special cases skip CALC and go straight to DONE with the result:
  - divisor 0: DIV/DIVU → all-ones; REM/REMU → `src_a`.
  - signed overflow (`src_a` = 1 followed by zeros, `src_b` = all-ones, DIV/REM): DIV → `src_a`; REM → 0.
- CALC multiply: radix-2 shift-add into a 2·XLEN accumulator, one bit per cycle.
- CALC divide: restoring shift-subtract, one quotient bit per cycle.
- CALC lasts exactly XLEN cycles. The counter decrements and exits to FIXUP when it reaches 1.
- FIXUP: apply two's-complement sign correction. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- FIXUP result selection:
  - MUL → low XLEN bits of the product.
  - MULH/MULHSU/MULHU → high XLEN bits.
  - Then go to DONE.
- DONE: `done`=1, drive `result`/`rd_out`, go to IDLE next cycle.
- `start` while busy is ignored; the hazard unit guarantees it is held.
- `flush` in any state → IDLE next edge, no `done`. `flush` has priority over `start` in IDLE and over DONE's pulse (`done` is forced 0 in a flushed cycle).
- All arithmetic is unsigned on magnitudes. The accumulator is 2·XLEN wide and the remainder register XLEN+1 wide. Intermediate results never overflow.

## Timing
- Reset (async assert, `reset`=0): state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter=0.
- Reset is released synchronously into IDLE. Reset mid-operation discards the op with no `done`.
- Start accepted in cycle 0. Normal path: CALC cycles 1..XLEN, FIXUP cycle XLEN+1, `done` in cycle XLEN+2 (34 for XLEN=32).
- Special-case path: `done` in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after DONE. A new `start` is accepted in the cycle `busy` is 0.
- `result` holds its last value outside DONE (registered, no glitching).

## Configuration
- `MULDIV_FAST_MUL_EN` defined: all multiply ops compute a full 2·XLEN product combinationally in IDLE and register it. They go IDLE→DONE with `done` in cycle 1. Divide is unchanged.
- Macro undefined: multiply uses the iterative CALC/FIXUP path with XLEN+2 latency. No hardware multiplier is inferred.

## Structure
- `muldiv_pkg` holds:
  - `muldiv_op_t` enum (8 funct3 encodings)
  - `muldiv_state_t` enum (IDLE, CALC, FIXUP, DONE)
  - localparams for the div-by-zero quotient and the signed-overflow constants, derived from XLEN.
- Sub-module `muldiv_step`: combinational single iteration. Takes mode, accumulator/remainder, and operand; returns the next accumulator/remainder. It is instantiated once in the CALC datapath.

## Test plan
- DIV: `src_a`=-7, `src_b`=2 → `result`=-3 (0xFFFFFFFD), `done` exactly 34 cycles after `start`. REM with the same operands → 0xFFFFFFFF (-1).
- DIVU: `src_a`=100, `src_b`=0 → 0xFFFFFFFF in cycle 1. REMU with the same operands → 100 in cycle 1.
- DIV: `src_a`=0x80000000, `src_b`=0xFFFFFFFF → 0x80000000 in cycle 1. REM with the same operands → 0.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL: same operands → 0x00000001. Latency is 34 without the macro and 1 with `MULDIV_FAST_MUL_EN`.
- Assert `flush` in cycle 10 of a DIV → `busy`=0 in cycle 11 and no `done`. Next `start` (DIVU 9/3) → `result`=3 with `rd_out` matching the new `rd_in`.
- Drive `reset` low mid-CALC → outputs zero immediately (async). Re-issued MULHSU (-1 × 0xFFFFFFFF) → 0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;
    localparam logic [MULDIV_XLEN-1:0] MULDIV_DIV0_QUOT    = {MULDIV_XLEN{1'b1}};
    localparam logic [MULDIV_XLEN-1:0] MULDIV_OVF_DIVIDEND = {1'b1, {(MULDIV_XLEN-1){1'b0}}};
    localparam logic [MULDIV_XLEN-1:0] MULDIV_OVF_DIVISOR  = {MULDIV_XLEN{1'b1}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } muldiv_state_t;

    function automatic logic op_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic [2:0]            op;
    logic [XLEN-1:0]       src_a;
    logic [XLEN-1:0]       src_b;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd_out;

    modport master (
        output start, op, src_a, src_b, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, src_a, src_b, rd_in, flush,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the CALC datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide on unsigned magnitudes.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              mul_mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN:0]     rem_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out,
    output logic [XLEN:0]     rem_out
);
    logic [XLEN:0]   sum;
    logic [XLEN+1:0] rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;

    always_comb begin
        // multiply: acc = {partial product, remaining multiplier bits}
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        // divide: low half of acc holds the dividend, shifted out MSB-first
        rem_sh  = {rem_in, acc_in[XLEN-1]};
        diff    = rem_sh - {2'b00, operand};
        ge      = ~diff[XLEN+1];
        if (mul_mode) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
            rem_out = rem_in;
        end else begin
            acc_out = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-2:0], ge};
            rem_out = ge ? diff[XLEN:0] : rem_sh[XLEN:0];
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with flush and one-cycle done pulse.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
//
// state    | meaning
// ST_IDLE  | waiting for start; operands decoded and latched on accept
// ST_CALC  | XLEN iterations of shift-add / shift-subtract
// ST_FIXUP | sign correction and result selection
// ST_DONE  | done pulse, result and rd_out valid
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN + 1);
    // widen the package's reference constants to this instance's XLEN
    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{MULDIV_DIV0_QUOT[0]}};
    localparam logic [XLEN-1:0] OVF_B     = {XLEN{MULDIV_OVF_DIVISOR[0]}};
    localparam logic [XLEN-1:0] OVF_A     = {MULDIV_OVF_DIVIDEND[MULDIV_XLEN-1],
                                             {(XLEN-1){MULDIV_OVF_DIVIDEND[0]}}};

    muldiv_state_t         state;
    muldiv_op_t            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rd_out_q;
    logic [XLEN-1:0]       operand_q;
    logic [XLEN-1:0]       result_q;
    logic [2*XLEN-1:0]     acc_q;
    logic [2*XLEN-1:0]     acc_nxt;
    logic [XLEN:0]         rem_q;
    logic [XLEN:0]         rem_nxt;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sign_q;

    muldiv_op_t        op_in;
    logic              a_neg, b_neg, sign_in, is_div_in, div_zero, sgn_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        op_in       = muldiv_op_t'(bus.op);
        a_neg       = op_signed_a(op_in) & bus.src_a[XLEN-1];
        b_neg       = op_signed_b(op_in) & bus.src_b[XLEN-1];
        mag_a       = a_neg ? -bus.src_a : bus.src_a;
        mag_b       = b_neg ? -bus.src_b : bus.src_b;
        // remainder follows the dividend's sign, everything else the XOR
        sign_in     = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
        is_div_in   = bus.op[2];
        div_zero    = is_div_in && (bus.src_b == '0);
        sgn_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (bus.src_a == OVF_A) && (bus.src_b == OVF_B);
        if (div_zero) special_res = bus.op[1] ? bus.src_a : DIV0_QUOT;
        else          special_res = bus.op[1] ? '0 : bus.src_a;
    end

    always_comb begin
        prod_fix = sign_q ? -acc_q : acc_q;
        quot_fix = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_res = quot_fix;
            default:                     fix_res = rem_fix;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_a    = {{XLEN{a_neg}}, bus.src_a};
        fast_b    = {{XLEN{b_neg}}, bus.src_b};
        fast_prod = fast_a * fast_b;
        fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mul_mode (~op_q[2]),
        .acc_in   (acc_q),
        .rem_in   (rem_q),
        .operand  (operand_q),
        .acc_out  (acc_nxt),
        .rem_out  (rem_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            rd_out_q  <= '0;
            operand_q <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q      <= op_in;
                        rd_q      <= bus.rd_in;
                        sign_q    <= sign_in;
                        operand_q <= mag_b;
                        acc_q     <= {{XLEN{1'b0}}, mag_a};
                        rem_q     <= '0;
                        cnt_q     <= CNT_W'(XLEN);
                        if (div_zero || sgn_ovf) begin
                            result_q <= special_res;
                            rd_out_q <= bus.rd_in;
                            state    <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div_in) begin
                            result_q <= fast_res;
                            rd_out_q <= bus.rd_in;
                            state    <= ST_DONE;
                        end
`endif
                        else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    result_q <= fix_res;
                    rd_out_q <= rd_q;
                    state    <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE) && !bus.flush;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule
